// File: rtl/fma16_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : fma16_share_arb
// Purpose : Round-robin sharing of one half-precision FMA datapath between two
//           requesters. Operation ids ride a tag pipe alongside the datapath
//           latency. Results come back through an in-order FIFO. Issue is
//           credit-gated so the FIFO can never overflow.
// Ports   : clk, reset (async, active-high)
//           req{0,1}_valid/_ready/_x/_y/_z  : operation request channels
//           fma_valid, fma_x/y/z            : registered issue to datapath
//           fma_result, fma_special         : datapath return, LAT cycles later
//           rsp{0,1}_valid/_ready/_result/_special : response channels
// Rev     : 1.0  initial release
// ============================================================================
module fma16_share_arb #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  output logic        fma_valid,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  input  logic [15:0] fma_result,
  input  logic        fma_special,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp0_special,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        rsp1_special
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 5;  // wide enough for (LAT+1) + DEPTH at the legal maximum

  // Round-robin preference: 0 favours req0, 1 favours req1.
  logic rr_q;

  // Tag pipe. Stage 0 is the issue register itself, so every accepted but not
  // yet pushed operation is counted, including the one currently on fma_*.
  logic        vld_q [LAT+1];
  logic        id_q  [LAT+1];
  logic [15:0] x_q, y_q, z_q;

  // Result FIFO.
  logic [15:0]   res_mem_q [DEPTH];
  logic          spc_mem_q [DEPTH];
  logic          idm_mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;

  logic          grant0, grant1, can_issue, acc0, acc1, acc;
  logic [CW-1:0] inflight;
  logic          push, pop, nonempty, head_id;

  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid |  rr_q);

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  // Registered counts only: a pop this cycle frees its credit next cycle.
  assign can_issue  = (inflight + CW'(cnt_q)) < CW'(DEPTH);
  assign req0_ready = grant0 & can_issue;
  assign req1_ready = grant1 & can_issue;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign acc        = acc0 | acc1;

  assign fma_valid  = vld_q[0];
  assign fma_x      = x_q;
  assign fma_y      = y_q;
  assign fma_z      = z_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      for (int i = 0; i <= LAT; i++) begin
        vld_q[i] <= 1'b0;
        id_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= acc;
      if (acc) begin
        id_q[0] <= acc1;
        x_q     <= acc1 ? req1_x : req0_x;
        y_q     <= acc1 ? req1_y : req0_y;
        z_q     <= acc1 ? req1_z : req0_z;
        rr_q    <= acc0;  // next preference goes to the other requester
      end
      for (int i = 1; i <= LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  // The exit stage lines up with the datapath result (same cycle for LAT=0).
  assign push     = vld_q[LAT];
  assign nonempty = (cnt_q != '0);
  assign head_id  = idm_mem_q[rd_q];

  assign rsp0_valid   = nonempty & ~head_id;
  assign rsp1_valid   = nonempty &  head_id;
  assign rsp0_result  = res_mem_q[rd_q];
  assign rsp1_result  = res_mem_q[rd_q];
  assign rsp0_special = spc_mem_q[rd_q];
  assign rsp1_special = spc_mem_q[rd_q];
  assign pop          = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (~push & pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;  // DEPTH is a power of two: natural wrap
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_q] <= fma_result;
      spc_mem_q[wr_q] <= fma_special;
      idm_mem_q[wr_q] <= id_q[LAT];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fma16_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_fma16_share_arb
// Purpose : Self-checking bench for fma16_share_arb with a behavioural
//           datapath stub (LAT=2, DEPTH=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fma16_share_arb;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_x = '0, req0_y = '0, req0_z = '0;
  logic [15:0] req1_x = '0, req1_y = '0, req1_z = '0;
  logic        fma_valid;
  logic [15:0] fma_x, fma_y, fma_z, fma_result;
  logic        fma_special;
  logic        rsp0_valid, rsp1_valid, rsp0_special, rsp1_special;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [15:0] rsp0_result, rsp1_result;

  always #5 clk = ~clk;

  fma16_share_arb #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .fma_valid(fma_valid), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_result(fma_result), .fma_special(fma_special),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_special(rsp0_special),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_special(rsp1_special)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural half-precision datapath ----------------
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) begin
      m = real'(h[9:0]) / 1024.0;
      e = -14;
    end else begin
      m = 1.0 + real'(h[9:0]) / 1024.0;
      e = int'(h[14:10]) - 15;
    end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  a;
    int   e;
    int   mant;
    logic s;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    if (a == 0.0) return 16'h0000;
    while (a >= 2.0 && e <= 16) begin a = a / 2.0; e++; end
    while (a < 1.0 && e >= -15) begin a = a * 2.0; e--; end
    if (e > 15)  return {s, 15'h7C00};
    if (e < -14) return {s, 15'h0000};
    mant = $rtoi((a - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(mant)};
  endfunction

  // Returns {special, result}: any Inf/NaN operand gives quiet NaN and flag.
  function automatic logic [16:0] fma_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    if (x[14:10] == 5'h1F || y[14:10] == 5'h1F || z[14:10] == 5'h1F)
      return {1'b1, 16'h7E00};
    return {1'b0, r2h(h2r(x) * h2r(y) + h2r(z))};
  endfunction

  logic [15:0] st_x [LAT], st_y [LAT], st_z [LAT];
  always @(posedge clk) begin
    st_x[0] <= fma_x;
    st_y[0] <= fma_y;
    st_z[0] <= fma_z;
    for (int i = 1; i < LAT; i++) begin
      st_x[i] <= st_x[i-1];
      st_y[i] <= st_y[i-1];
      st_z[i] <= st_z[i-1];
    end
  end
  assign {fma_special, fma_result} = fma_model(st_x[LAT-1], st_y[LAT-1], st_z[LAT-1]);

  // ---------------- transaction-level reference model ----------------
  // Every accepted op is queued in issue order with the cycle at which it
  // first becomes presentable; it leaves the queue when its owner takes it.
  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        spc;
    int          avail;
  } op_t;

  op_t q[$];
  int  pref = 0;
  int  cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      pref = 0;
    end else begin
      logic        e_can, e_g0, e_g1, hv, hid;
      logic [16:0] r;
      op_t         o;
      e_can = (q.size() < DEPTH);
      e_g0  = req0_valid && (!req1_valid || pref == 0);
      e_g1  = req1_valid && (!req0_valid || pref == 1);
      check("mon_req0_ready", req0_ready, e_g0 && e_can);
      check("mon_req1_ready", req1_ready, e_g1 && e_can);
      hv  = (q.size() > 0) && (q[0].avail <= cyc);
      hid = hv ? q[0].id : 1'b0;
      check("mon_rsp0_valid", rsp0_valid, hv && !hid);
      check("mon_rsp1_valid", rsp1_valid, hv && hid);
      if (hv) begin
        check("mon_result", hid ? rsp1_result : rsp0_result, q[0].res);
        check("mon_special", hid ? rsp1_special : rsp0_special, q[0].spc);
        if ((!hid && rsp0_ready) || (hid && rsp1_ready)) void'(q.pop_front());
      end
      if (req0_valid && req0_ready) begin
        r = fma_model(req0_x, req0_y, req0_z);
        o.id = 1'b0; o.res = r[15:0]; o.spc = r[16]; o.avail = cyc + 2 + LAT;
        q.push_back(o);
        pref = 1;
      end else if (req1_valid && req1_ready) begin
        r = fma_model(req1_x, req1_y, req1_z);
        o.id = 1'b1; o.res = r[15:0]; o.spc = r[16]; o.avail = cyc + 2 + LAT;
        q.push_back(o);
        pref = 0;
      end
      check("mon_no_overflow", q.size() <= DEPTH, 1'b1);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        id;
    logic [15:0] x, y, z;
    logic [15:0] res;
    logic        spc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int k;
    bit got;
    @(posedge clk); #1;
    if (v.id) begin
      req1_valid = 1'b1; req1_x = v.x; req1_y = v.y; req1_z = v.z;
    end else begin
      req0_valid = 1'b1; req0_x = v.x; req0_y = v.y; req0_z = v.z;
    end
    @(negedge clk);
    check("vec_ready", v.id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = v.id ? rsp1_valid : rsp0_valid;
    end
    check("vec_latency", k, LAT + 2);
    check("vec_result", v.id ? rsp1_result : rsp0_result, v.res);
    check("vec_special", v.id ? rsp1_special : rsp0_special, v.spc);
    check("vec_other_valid", v.id ? rsp0_valid : rsp1_valid, 1'b0);
  endtask

  initial begin
    vec_t vecs [8];
    int   n;
    bit   g, prev;
    logic [15:0] rv;

    vecs[0] = '{1'b0, 16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 1'b0};  // 1*2+1 = 3
    vecs[1] = '{1'b1, 16'h7E00, 16'h3C00, 16'h3C00, 16'h7E00, 1'b1};  // NaN operand
    vecs[2] = '{1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h4400, 1'b0};  // 2*2+0 = 4
    vecs[3] = '{1'b0, 16'h3800, 16'h4000, 16'h3C00, 16'h4000, 1'b0};  // 0.5*2+1 = 2
    vecs[4] = '{1'b0, 16'hC000, 16'h3C00, 16'h4000, 16'h0000, 1'b0};  // -2+2 = 0
    vecs[5] = '{1'b1, 16'h4200, 16'h4200, 16'h0000, 16'h4880, 1'b0};  // 3*3 = 9
    vecs[6] = '{1'b0, 16'h3C00, 16'h3C00, 16'hBC00, 16'h0000, 1'b0};  // 1-1 = 0
    vecs[7] = '{1'b0, 16'h7C00, 16'h3C00, 16'h0000, 16'h7E00, 1'b1};  // Inf operand

    // Reset state
    #12;
    check("reset_fma_valid", fma_valid, 1'b0);
    check("reset_fma_xyz", {fma_x, fma_y, fma_z}, 32'h0);
    check("reset_fma_z", fma_z, 16'h0);
    check("reset_rsp0_valid", rsp0_valid, 1'b0);
    check("reset_rsp1_valid", rsp1_valid, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Alternating grants with both requesters streaming, req0 first
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = 16'h3C00; req0_y = 16'h3C00; req0_z = 16'h0000;
    req1_valid = 1'b1; req1_x = 16'h4000; req1_y = 16'h3C00; req1_z = 16'h0000;
    n = 0;
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rr_one_ready", req0_ready & req1_ready, 1'b0);
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        if (n == 0) check("rr_first_grant", g, 1'b0);
        else        check("rr_alternate", g, !prev);
        prev = g;
        n++;
      end
    end
    check("rr_made_progress", n >= 6, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Single-operation vectors
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    repeat (4) @(negedge clk);

    // Credit gating with a stalled response port
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h4000; req0_z = 16'h3C00;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req0_ready) n++;
    end
    check("blocked_accepts", n, DEPTH);
    check("blocked_ready", req0_ready, 1'b0);
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_rsp0_valid", rsp0_valid, 1'b1);
    check("pop_cycle_ready", req0_ready, 1'b0);
    @(negedge clk);
    check("accept_after_pop", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Head-of-line blocking
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_x = 16'h3C00; req1_y = 16'h3C00; req1_z = 16'h3C00;
    @(negedge clk);
    check("hol_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_x = 16'h4000; req0_y = 16'h3C00; req0_z = 16'h0000;
    @(negedge clk);
    check("hol_req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("hol_rsp0_blocked", rsp0_valid, 1'b0);
    end
    check("hol_rsp1_head", rsp1_valid, 1'b1);
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hol_rsp0_after_pop", rsp0_valid, 1'b1);
    repeat (6) @(negedge clk);

    // Asynchronous reset with operations in flight
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = 16'h3C00; req0_y = 16'h4000; req0_z = 16'h3C00;
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (req0_ready) n++;
    end
    check("pre_reset_accepts", n, 3);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("pre_reset_fma_valid", fma_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("reset_async_fma_valid", fma_valid, 1'b0);
    check("reset_async_rsp0_valid", rsp0_valid, 1'b0);
    check("reset_async_rsp1_valid", rsp1_valid, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_reset_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
      check("post_reset_no_issue", fma_valid, 1'b0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("post_reset_rr", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      rv = 16'($urandom); req0_x = ($urandom_range(0, 7) == 0) ? {rv[15], 5'h1F, rv[9:0]} : {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rv = 16'($urandom); req0_y = {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rv = 16'($urandom); req0_z = {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rv = 16'($urandom); req1_x = ($urandom_range(0, 7) == 0) ? {rv[15], 5'h1F, rv[9:0]} : {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rv = 16'($urandom); req1_y = {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rv = 16'($urandom); req1_z = {rv[15], 5'($urandom_range(12, 18)), rv[9:0]};
      rsp0_ready = ($urandom_range(0, 99) < 70);
      rsp1_ready = ($urandom_range(0, 99) < 70);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
